// File: rtl/montgomery_reduce_arbiter_if.sv
// montgomery_reduce_arbiter_if: requester handshake and Montgomery-unit signals of the shared reduce arbiter.
// slave is the arbiter side; master is the requesters plus the unit.
interface montgomery_reduce_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int COEFF_W = 16
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ*COEFF_W-1:0] req_a;
    logic [N_REQ*COEFF_W-1:0] req_b;
    logic [COEFF_W-1:0]       rsp_data;
    logic                     rsp_err;
    logic                     busy;
    logic                     mr_enable;
    logic [COEFF_W-1:0]       mr_a;
    logic [COEFF_W-1:0]       mr_b;
    logic                     mr_done;
    logic [COEFF_W-1:0]       mr_result;

    modport slave (
        input  req_valid, req_a, req_b, mr_done, mr_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, mr_enable, mr_a, mr_b
    );

    modport master (
        output req_valid, req_a, req_b, mr_done, mr_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, mr_enable, mr_a, mr_b
    );
endinterface

// File: rtl/montgomery_reduce_arbiter.sv
// montgomery_reduce_arbiter: round-robin sharing of one Montgomery multiply-reduce unit among N_REQ requesters.
// Optional WAIT-state timeout enabled by defining MR_ARB_TIMEOUT_EN.
module montgomery_reduce_arbiter #(
    parameter int N_REQ   = 2,
    parameter int COEFF_W = 16,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic reset_n,
    montgomery_reduce_arbiter_if.slave bus
);
    localparam int GW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("montgomery_reduce_arbiter: parameter out of range");
    end

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d, last_q, last_d, pick, cand;
    logic               found;
    logic [COEFF_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic               mr_enable_q, mr_enable_d, busy_q, busy_d;
`ifdef MR_ARB_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = (last_q == GW'(N_REQ - 1)) ? '0 : last_q + GW'(1);
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == GW'(N_REQ - 1)) ? '0 : cand + GW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        rsp_valid_d = '0;
        mr_enable_d = 1'b0;
`ifdef MR_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                state_d     = ISSUE;
                grant_d     = pick;
                op_a_d      = bus.req_a[pick*COEFF_W +: COEFF_W];
                op_b_d      = bus.req_b[pick*COEFF_W +: COEFF_W];
                mr_enable_d = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MR_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
`ifdef MR_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (bus.mr_done) begin
                    state_d     = RESP;
                    res_d       = bus.mr_result;
                    rsp_valid_d = N_REQ'(1) << grant_q;
`ifdef MR_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                    state_d     = RESP;
                    res_d       = '0;
                    rsp_valid_d = N_REQ'(1) << grant_q;
                    err_d       = 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= GW'(N_REQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
            mr_enable_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MR_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            mr_enable_q <= mr_enable_d;
            busy_q      <= busy_d;
`ifdef MR_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Accept is combinational so the handshake closes in the arbitration cycle.
    assign bus.req_ready = (reset_n && state_q == IDLE && found) ? N_REQ'(1) << pick : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = res_q;
    assign bus.busy      = busy_q;
    assign bus.mr_enable = mr_enable_q;
    assign bus.mr_a      = op_a_q;
    assign bus.mr_b      = op_b_q;
`ifdef MR_ARB_TIMEOUT_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_montgomery_reduce_arbiter.sv
// tb_montgomery_reduce_arbiter: scoreboard bench for the Montgomery reduce arbiter with a 4-stage unit model.
module tb_montgomery_reduce_arbiter;
    localparam int N = 2, W = 16, TO = 16;

    typedef struct {
        logic [N-1:0] who;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    montgomery_reduce_arbiter_if #(.N_REQ(N), .COEFF_W(W)) bus ();
    montgomery_reduce_arbiter #(.N_REQ(N), .COEFF_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    exp_t sb[$];
    logic real_en = 1'b1;
    logic stub_done = 1'b0;
    logic [W-1:0] stub_res = '0;
    logic model_done;
    logic [W-1:0] model_res, prod;
    int mcnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        int p, q, r;
        logic signed [15:0] t;
        p = int'($signed(a)) * int'($signed(b));
        q = p * -3327;
        t = q[15:0];
        r = (p - int'(t) * 3329) >>> 16;
        return r[15:0];
    endfunction

    // Unit model: done arrives five cycles after the enable cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt <= 0;
            model_done <= 1'b0;
            model_res <= '0;
            prod <= '0;
        end else begin
            model_done <= 1'b0;
            if (real_en && bus.mr_enable) begin
                mcnt <= 4;
                prod <= mont(bus.mr_a, bus.mr_b);
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    model_done <= 1'b1;
                    model_res <= prod;
                end
            end
        end
    end

    assign bus.mr_done = model_done | stub_done;
    assign bus.mr_result = real_en ? model_res : stub_res;

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b data=%h, required no response", bus.rsp_valid, bus.rsp_data);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_valid !== e.who || bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                             bus.rsp_valid, bus.rsp_data, bus.rsp_err, e.who, e.data, e.err);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_rsp(input int a, input int lat, input string nm);
        int n = 0;
        while (bus.rsp_valid == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60 || cyc - a != lat) begin
            errors++;
            $display("FAIL %s: response after %0d cycles, required %0d", nm, cyc - a, lat);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got ready=%b rsp=%b err=%b, required 0", bus.req_ready, bus.rsp_valid, bus.rsp_err);
        end
        checks++;
        if (bus.rsp_data !== '0 || bus.busy !== 1'b0 || bus.mr_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got data=%h busy=%b en=%b, required 0", bus.rsp_data, bus.busy, bus.mr_enable);
        end
        checks++;
        if (bus.mr_a !== '0 || bus.mr_b !== '0) begin
            errors++;
            $display("FAIL reset_ops: got mr_a=%h mr_b=%h, required 0", bus.mr_a, bus.mr_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int a;
        do_reset();
        @(negedge clk);
        bus.req_a = {16'h0000, 16'h0001};
        bus.req_b = {16'h0000, 16'h0001};
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b, required 01", bus.req_ready);
        end
        sb.push_back('{2'b01, 16'h00A9, 1'b0});
        a = cyc;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b00 || bus.mr_enable !== 1'b1 || bus.busy !== 1'b1 || bus.mr_a !== 16'h1 || bus.mr_b !== 16'h1) begin
            errors++;
            $display("FAIL single_issue: got ready=%b en=%b busy=%b a=%h b=%h, required 00 1 1 0001 0001",
                     bus.req_ready, bus.mr_enable, bus.busy, bus.mr_a, bus.mr_b);
        end
        bus.req_valid = '0;
        wait_rsp(a, 7, "single_latency");
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b rsp=%b, required 0 00", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] opa [4];
        logic [W-1:0] opb [4];
        logic [N-1:0] eg;
        int k = 0, n = 0, t0 = 0, upd = -1;
        opa = '{16'h0001, 16'hFB2E, 16'h7FFF, 16'h8000};
        opb = '{16'h0001, 16'h0BB8, 16'h7FFF, 16'h0005};
        do_reset();
        @(negedge clk);
        bus.req_a = {opa[1], opa[0]};
        bus.req_b = {opb[1], opb[0]};
        bus.req_valid = 2'b11;
        while (k < 4 && n < 100) begin
            if (upd >= 0 && upd + 2 < 4) begin
                bus.req_a[(upd % 2)*W +: W] = opa[upd + 2];
                bus.req_b[(upd % 2)*W +: W] = opb[upd + 2];
            end
            upd = -1;
            #1;
            if (bus.req_ready != '0) begin
                eg = (k % 2 == 0) ? 2'b01 : 2'b10;
                if (k == 0) t0 = cyc;
                checks++;
                if (bus.req_ready !== eg || cyc - t0 != 8 * k) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got ready=%b at +%0d, required %b at +%0d", k, bus.req_ready, cyc - t0, eg, 8 * k);
                end
                sb.push_back('{eg, mont(opa[k], opb[k]), 1'b0});
                upd = k;
                k++;
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = '0;
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d accepts, required 4", k);
        end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_req1_only();
        int a;
        do_reset();
        @(negedge clk);
        bus.req_a = {16'h0000, 16'h1234};
        bus.req_b = {16'h0D00, 16'h1234};
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL req1_ready: got %b, required 10", bus.req_ready);
        end
        sb.push_back('{2'b10, 16'h0000, 1'b0});
        a = cyc;
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(a, 7, "req1_latency");
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        do_reset();
        @(negedge clk);
        bus.req_a = {16'h0003, 16'h0005};
        bus.req_b = {16'h0004, 16'h0007};
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mr_enable !== 1'b0 || bus.mr_a !== '0 || bus.mr_b !== '0 ||
            bus.rsp_valid !== '0 || bus.rsp_data !== '0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b en=%b a=%h b=%h rsp=%b data=%h ready=%b, required all 0",
                     bus.busy, bus.mr_enable, bus.mr_a, bus.mr_b, bus.rsp_valid, bus.rsp_data, bus.req_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_norsp: got %0d responses, required 0", seen);
        end
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_grant: got %b, required 01", bus.req_ready);
        end
        sb.push_back('{2'b01, mont(16'h0005, 16'h0007), 1'b0});
        @(negedge clk);
        bus.req_valid = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_stray_done();
        int a;
        do_reset();
        real_en = 1'b0;
        @(negedge clk);
        stub_res = 16'h1111;
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
            errors++;
            $display("FAIL stray_idle: got busy=%b rsp=%b, required 0 00", bus.busy, bus.rsp_valid);
        end
        @(negedge clk);
        bus.req_a = {16'h0000, 16'h0009};
        bus.req_b = {16'h0000, 16'h0009};
        bus.req_valid = 2'b01;
        sb.push_back('{2'b01, 16'h3333, 1'b0});
        a = cyc;
        @(negedge clk);
        bus.req_valid = '0;
        stub_res = 16'h2222;
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
        repeat (2) @(negedge clk);
        stub_res = 16'h3333;
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
        wait_rsp(a, 5, "stray_latency");
        real_en = 1'b1;
    endtask

`ifdef MR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int a;
        do_reset();
        real_en = 1'b0;
        @(negedge clk);
        bus.req_a = {16'h0000, 16'h0042};
        bus.req_b = {16'h0000, 16'h0043};
        bus.req_valid = 2'b01;
        sb.push_back('{2'b01, 16'h0000, 1'b1});
        a = cyc;
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(a, TO + 2, "timeout_latency");
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy);
        end
        real_en = 1'b1;
    endtask
`endif

    initial begin
        int n = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_req1_only();
        test_mid_reset();
        test_stray_done();
`ifdef MR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/montgomery_reduce_arbiter.md
# montgomery_reduce_arbiter

- Shares one Montgomery multiply-reduce unit (enable/done handshake, 16-bit signed coefficients) between up to four requesters.
- Requesters are typically the lanes of the polyvec base-multiply/accumulate path.
- Grants are round-robin. The block latches operands, pulses the unit's enable, waits for done, and returns the result to the granted requester.
- Exactly one operation is in flight at a time.

## Interface

Parameters:
- N_REQ, 2 — number of requesters, legal range 2..4
- COEFF_W, 16 — operand and result width
- TIMEOUT, 16 — WAIT-state cycle limit; used only with MR_ARB_TIMEOUT_EN

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  — clock
- reset_n  in  1  — asynchronous active-low reset
- req_valid  in  N_REQ  — per-requester operation request
- req_a  in  N_REQ*COEFF_W  — packed operand a; requester i occupies bits [i*COEFF_W +: COEFF_W]
- req_b  in  N_REQ*COEFF_W  — packed operand b, same packing
- req_ready  out  N_REQ  — one-hot accept pulse
- rsp_valid  out  N_REQ  — one-hot result pulse
- rsp_data  out  COEFF_W  — result; valid while any rsp_valid bit is high
- rsp_err  out  1  — result invalid (timeout); qualified by rsp_valid
- busy  out  1  — high in every state except IDLE
- mr_enable  out  1  — start pulse to the Montgomery unit
- mr_a  out  COEFF_W  — operand a to the unit
- mr_b  out  COEFF_W  — operand b to the unit
- mr_done  in  1  — completion from the unit; a single-cycle pulse
- mr_result  in  COEFF_W  — unit result, valid when mr_done=1

## Operation

FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any req_valid is high, select grant g: the first requester with req_valid=1, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - Assert req_ready[g] combinationally in this cycle. The handshake completes on req_valid[g] & req_ready[g].
  - Latch req_a[g] and req_b[g] into op_a and op_b, store g, go to ISSUE.
- **ISSUE**: mr_enable=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On mr_done=1: capture mr_result into res and go to RESP.
  - mr_done is ignored in every state other than WAIT.
- **RESP**
  - rsp_valid[g]=1 and rsp_data=res for one cycle.
  - last_grant <= g, then go to IDLE.
- mr_a and mr_b are driven from op_a and op_b. They stay stable from ISSUE through the WAIT cycle in which mr_done is seen.
- req_ready is 0 outside IDLE. req_valid is sampled only in IDLE.
  - A requester must hold req_valid and its operands until accepted.
  - Dropping req_valid before acceptance withdraws the request without error.
- Arithmetic: none in this block. Operands and result pass through unchanged as signed COEFF_W two's complement.
- Reset mid-operation:
  - All state is cleared immediately and the FSM goes to IDLE.
  - Any in-flight result is discarded, with no rsp_valid.
  - The Montgomery unit is assumed to be reset by the same reset_n.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, mr_enable=0, mr_a=0, mr_b=0.
  - last_grant=N_REQ-1, so requester 0 wins the first arbitration.

## Timing

- With the standard 4-stage Montgomery unit:
  - accept in cycle A; mr_enable in A+1; unit states span A+2..A+5; mr_done in A+6; rsp_valid in A+7.
  - Latency from accept to response is 7 cycles.
- Next accept is possible no earlier than A+8. Peak throughput is one operation per 8 cycles.
- General case: latency = 1 + (enable-to-done cycles) + 1.
- Only one req_ready bit and one rsp_valid bit may be high at any time.
- A requester's request for the next operation can be accepted no earlier than the cycle after its rsp_valid.

## Configuration

Macro: MR_ARB_TIMEOUT_EN.
- **Defined**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mr_done, go to RESP with rsp_data=0 and rsp_err=1.
  - A later stray mr_done is ignored unless it arrives in WAIT.
- **Not defined**
  - No counter is built; WAIT waits indefinitely.
  - rsp_err is tied to 0.

## Test plan

- Reset, then req_valid=01 with a=0x0001, b=0x0001 (real unit):
  - req_ready=01 in cycle A, mr_enable in A+1.
  - rsp_valid=01 and rsp_data=0x00A9 (169) in A+7.
- req_valid=11 held continuously:
  - grants alternate 0,1,0,1 over 4 operations, at accepts A, A+8, A+16, A+24.
  - rsp_valid never has more than one bit set.
- req_valid=10 only, with a=0x0000, b=0x0D00: requester 1 is granted immediately; rsp_data=0x0000.
- Stub unit with mr_done held 0 and MR_ARB_TIMEOUT_EN defined:
  - rsp_valid in cycle A+1+TIMEOUT+1 with rsp_err=1 and rsp_data=0.
  - busy=0 one cycle later.
- Assert reset_n low in the cycle after mr_enable:
  - all outputs return to reset values immediately; no rsp_valid follows.
  - the next request after reset goes to requester 0 first.
- Stub pulses mr_done during IDLE and ISSUE: the pulse is ignored; response comes only from the done pulse seen in WAIT.
